sine_sequencer: RTL

- Controller that plays the 56-entry half-sine lookup table as a continuous raised-cosine waveform.
- Walks the table index up (0 to last) and back down (last−1 to 1), so consecutive periods join seamlessly.
- Step rate and number of periods are programmable; each new sample is registered with a one-cycle valid strobe.
- Sits between the lookup table and the downstream PWM/DAC stage, and is the only block that drives the table address.

---
 rtl/sine_pkg.sv | 19 +
 rtl/sine_sequencer_step_timer.sv | 44 ++++
 rtl/sine_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sine_pkg.sv
// Shared definitions for the sine sequencer slice.
//   SINE_SIZE  : width of one table sample
//   TABLE_SIZE : number of entries in the half-sine lookup table
//   INDEX_W    : width of a table index
//   state_t    : playback FSM states
package sine_pkg;

    localparam int unsigned SINE_SIZE  = 8;
    localparam int unsigned TABLE_SIZE = 56;
    localparam int unsigned INDEX_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL,
        FINISH
    } state_t;

endpackage

// File: rtl/sine_sequencer_step_timer.sv
// Prescaler down-counter that paces table steps.
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the counter to 0 so the next enabled clock ticks
//   en       : count (only while a waveform is playing)
//   div      : clocks per step, 0 treated as 1
//   tick     : high on enabled clocks where the counter is 0
module step_timer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d = (div == '0) ? '0 : div - DIV_W'(1);
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/sine_sequencer.sv
// Plays the half-sine lookup table as a continuous raised-cosine waveform:
// index walks 0..last then last-1..1, so consecutive periods join seamlessly.
//   clk, rst      : clock, synchronous active-high reset
//   start, stop   : begin playback (IDLE only) / stop at next period boundary
//   div, cycles   : clocks per step (0 -> 1) / periods to play (0 -> forever)
//   table_last    : last valid table index (>= 2)
//   table_index   : registered table address
//   table_data    : combinational table read of table_index
//   sample        : registered sample, sample_valid pulses once per new sample
//   falling       : sample on the output belongs to the descending half
//   cycle_end     : pulses with the last sample of each period
//   busy, done    : playback in progress / one-cycle end-of-playback pulse
module sine_sequencer #(
    parameter int unsigned SINE_SIZE = 8,
    parameter int unsigned INDEX_W   = 6,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DIV_W-1:0]     div,
    input  logic [CNT_W-1:0]     cycles,
    input  logic [INDEX_W-1:0]   table_last,
    output logic [INDEX_W-1:0]   table_index,
    input  logic [SINE_SIZE-1:0] table_data,
    output logic [SINE_SIZE-1:0] sample,
    output logic                 sample_valid,
    output logic                 falling,
    output logic                 cycle_end,
    output logic                 busy,
    output logic                 done
);

    import sine_pkg::*;

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   idx_q, idx_d;
    logic [SINE_SIZE-1:0] sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 falling_q, falling_d;
    logic                 cycle_end_q, cycle_end_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     cycles_q, cycles_d;
    logic [INDEX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]     period_q, period_d;

    logic                 tmr_clear;
    logic                 tmr_en;
    logic                 tick;
    logic                 last_period;

    step_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(tmr_clear),
        .en   (tmr_en),
        .div  (div_q),
        .tick (tick)
    );

    // Extra bit so the +1 cannot wrap before the comparison.
    assign last_period = (cycles_q != '0) &&
                         (({1'b0, period_q} + (CNT_W+1)'(1)) == {1'b0, cycles_q});

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        falling_d   = falling_q;
        cycle_end_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        div_d       = div_q;
        cycles_d    = cycles_q;
        last_d      = last_q;
        period_d    = period_q;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RISE;
                    busy_d      = 1'b1;
                    idx_d       = '0;
                    div_d       = div;
                    cycles_d    = cycles;
                    last_d      = table_last;
                    period_d    = '0;
                    stop_pend_d = stop;
                    tmr_clear   = 1'b1;
                end
            end

            RISE: begin
                tmr_en = 1'b1;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tick) begin
                    sample_d  = table_data;
                    valid_d   = 1'b1;
                    falling_d = 1'b0;
                    if (idx_q == last_q) begin
                        idx_d   = last_q - INDEX_W'(1);
                        state_d = FALL;
                    end else begin
                        idx_d = idx_q + INDEX_W'(1);
                    end
                end
            end

            FALL: begin
                tmr_en = 1'b1;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tick) begin
                    sample_d  = table_data;
                    valid_d   = 1'b1;
                    falling_d = 1'b1;
                    if (idx_q == INDEX_W'(1)) begin
                        cycle_end_d = 1'b1;
                        period_d    = (period_q == '1) ? period_q : period_q + CNT_W'(1);
                        // A stop arriving on the boundary clock counts as pending.
                        if (stop_pend_q || stop || last_period) begin
                            state_d = FINISH;
                        end else begin
                            idx_d   = '0;
                            state_d = RISE;
                        end
                    end else begin
                        idx_d = idx_q - INDEX_W'(1);
                    end
                end
            end

            FINISH: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                sample_d    = '0;
                idx_d       = '0;
                falling_d   = 1'b0;
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            falling_q   <= 1'b0;
            cycle_end_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            div_q       <= '0;
            cycles_q    <= '0;
            last_q      <= '0;
            period_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            falling_q   <= falling_d;
            cycle_end_q <= cycle_end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            div_q       <= div_d;
            cycles_q    <= cycles_d;
            last_q      <= last_d;
            period_q    <= period_d;
        end
    end

    assign table_index  = idx_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign falling      = falling_q;
    assign cycle_end    = cycle_end_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
